// File: rtl/fl_netcope_hdr_strip.sv
// fl_netcope_hdr_strip: strips the first FrameLink part (header) of each frame and forwards the rest
module fl_netcope_hdr_strip #(
  parameter int DATA_WIDTH = 64,
  parameter int REM_WIDTH  = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic [REM_WIDTH-1:0]  RX_REM,
  input  logic                  RX_SOF_N,
  input  logic                  RX_EOF_N,
  input  logic                  RX_SOP_N,
  input  logic                  RX_EOP_N,
  input  logic                  RX_SRC_RDY_N,
  output logic                  RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic [REM_WIDTH-1:0]  TX_REM,
  output logic                  TX_SOF_N,
  output logic                  TX_EOF_N,
  output logic                  TX_SOP_N,
  output logic                  TX_EOP_N,
  output logic                  TX_SRC_RDY_N,
  input  logic                  TX_DST_RDY_N,
  output logic [31:0]           FRAME_CNT,
  output logic [15:0]           DROP_CNT
);
  typedef enum logic [1:0] {HDR, PAY_FIRST, PAY} state_t;
  state_t state, state_nxt;
  logic valid, init, rx_xfer, tx_xfer, load, drop;
  assign RX_DST_RDY_N = ~RESET | init | (valid & TX_DST_RDY_N);
  assign TX_SRC_RDY_N = ~RESET | ~valid;
  assign rx_xfer = ~RX_SRC_RDY_N & ~RX_DST_RDY_N;
  assign tx_xfer = ~TX_SRC_RDY_N & ~TX_DST_RDY_N;
  // header words and stray frame starts are swallowed; payload words go to the output register
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    drop = 1'b0;
    if (rx_xfer) begin
      if (state == HDR || !RX_SOF_N) begin
        drop = !RX_EOF_N || state != HDR;
        state_nxt = (RX_EOF_N && !RX_EOP_N) ? PAY_FIRST : HDR;
      end else begin
        load = 1'b1;
        state_nxt = !RX_EOF_N ? HDR : PAY;
      end
    end
  end
  // state, output register and statistics counters
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= HDR;
      valid     <= 1'b0;
      init      <= 1'b1;
      TX_DATA   <= '0;
      TX_REM    <= '0;
      TX_SOF_N  <= 1'b1;
      TX_EOF_N  <= 1'b1;
      TX_SOP_N  <= 1'b1;
      TX_EOP_N  <= 1'b1;
      FRAME_CNT <= '0;
      DROP_CNT  <= '0;
    end else begin
      init  <= 1'b0;
      state <= state_nxt;
      valid <= load | (valid & ~tx_xfer);
      if (load) begin
        TX_DATA  <= RX_DATA;
        TX_REM   <= RX_REM;
        TX_SOF_N <= state != PAY_FIRST;
        TX_SOP_N <= (state == PAY_FIRST) ? 1'b0 : RX_SOP_N;
        TX_EOP_N <= RX_EOP_N;
        TX_EOF_N <= RX_EOF_N;
      end
      if (tx_xfer && !TX_EOF_N) FRAME_CNT <= FRAME_CNT + 32'd1;
      if (drop && DROP_CNT != 16'hFFFF) DROP_CNT <= DROP_CNT + 16'd1;
    end
  end
endmodule

// File: tb/tb_fl_netcope_hdr_strip.sv
// tb_fl_netcope_hdr_strip: directed self-checking bench for the header stripper
module tb_fl_netcope_hdr_strip;
  logic        CLK = 0;
  logic        RESET;
  logic [63:0] RX_DATA;
  logic [2:0]  RX_REM;
  logic        RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
  logic [63:0] TX_DATA;
  logic [2:0]  TX_REM;
  logic        TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N, TX_DST_RDY_N;
  logic [31:0] FRAME_CNT;
  logic [15:0] DROP_CNT;
  typedef struct packed {logic [63:0] d; logic [2:0] r; logic sof, eof, sop, eop;} word_t;
  word_t q[$];
  int checks = 0, errors = 0, stalls = 0;
  bit rand_rdy = 0;
  localparam logic [63:0] HDRW = 64'hAAAA_AAAA_AAAA_AAAA;

  fl_netcope_hdr_strip dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
    .RX_SOP_N(RX_SOP_N), .RX_EOP_N(RX_EOP_N), .RX_SRC_RDY_N(RX_SRC_RDY_N), .RX_DST_RDY_N(RX_DST_RDY_N),
    .TX_DATA(TX_DATA), .TX_REM(TX_REM), .TX_SOF_N(TX_SOF_N), .TX_EOF_N(TX_EOF_N),
    .TX_SOP_N(TX_SOP_N), .TX_EOP_N(TX_EOP_N), .TX_SRC_RDY_N(TX_SRC_RDY_N), .TX_DST_RDY_N(TX_DST_RDY_N),
    .FRAME_CNT(FRAME_CNT), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // collect TX transfers; while the register is full and blocked, upstream must be stalled
  always @(negedge CLK) begin
    if (RESET === 1'b1 && TX_SRC_RDY_N === 1'b0) begin
      if (TX_DST_RDY_N === 1'b0) q.push_back({TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N});
      else chk("stall_when_full", RX_DST_RDY_N, 1);
    end
  end

  task automatic send(input logic [63:0] d, input logic [2:0] r, input logic sof, eof, sop, eop);
    bit acc = 0;
    int n = 0;
    RX_DATA = d; RX_REM = r; RX_SOF_N = sof; RX_EOF_N = eof; RX_SOP_N = sop; RX_EOP_N = eop;
    RX_SRC_RDY_N = 0;
    while (!acc) begin
      if (rand_rdy) TX_DST_RDY_N = 1'($urandom_range(0, 1));
      @(negedge CLK);
      acc = (RX_DST_RDY_N === 1'b0);
      if (!acc) stalls++;
      @(posedge CLK); #1;
      if (!acc && ++n >= 1000) begin
        checks++; errors++;
        $error("FAIL send_timeout got=stalled exp=accepted");
        break;
      end
    end
    RX_SRC_RDY_N = 1;
  endtask

  task automatic idle(input int n);
    RX_SRC_RDY_N = 1;
    repeat (n) begin
      if (rand_rdy) TX_DST_RDY_N = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    RESET = 0; RX_SRC_RDY_N = 1; TX_DST_RDY_N = 0; RX_DATA = 0; RX_REM = 0;
    RX_SOF_N = 1; RX_EOF_N = 1; RX_SOP_N = 1; RX_EOP_N = 1;
    @(posedge CLK); #1;
    chk("rst_tx_src_rdy", TX_SRC_RDY_N, 1);
    chk("rst_rx_dst_rdy", RX_DST_RDY_N, 1);
    chk("rst_flags", {TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N}, 4'hF);
    chk("rst_data", TX_DATA, 0);
    chk("rst_rem", TX_REM, 0);
    chk("rst_cnts", {FRAME_CNT, DROP_CNT}, 0);
    RESET = 1;
    @(negedge CLK);
    chk("post_rst_rx_dst_rdy", RX_DST_RDY_N, 1);
    chk("post_rst_tx_src_rdy", TX_SRC_RDY_N, 1);
    @(posedge CLK); #1;
    chk("ready_after_rst", RX_DST_RDY_N, 0);
    // basic frame: 1 header word, 3 payload words
    q.delete();
    send(HDRW, 7, 0, 1, 0, 0);
    chk("hdr_not_forwarded", TX_SRC_RDY_N, 1);
    send(64'h01, 7, 1, 1, 0, 1);
    chk("latency_src_rdy", TX_SRC_RDY_N, 0);
    chk("latency_data", TX_DATA, 64'h01);
    send(64'h02, 7, 1, 1, 1, 1);
    send(64'h03, 5, 1, 0, 1, 0);
    idle(3);
    chk("basic_count", q.size(), 3);
    if (q.size() == 3) begin
      chk("basic_w0", {q[0].d, q[0].sof, q[0].sop}, {64'h01, 2'b00});
      chk("basic_w1", {q[1].d, q[1].sof, q[1].eof}, {64'h02, 2'b11});
      chk("basic_w2", {q[2].d, q[2].r, q[2].eof, q[2].eop}, {64'h03, 3'd5, 2'b00});
    end
    chk("basic_frame_cnt", FRAME_CNT, 1);
    chk("basic_drop_cnt", DROP_CNT, 0);
    // header-only frame
    q.delete();
    send(HDRW, 2, 0, 0, 0, 0);
    idle(2);
    chk("hdronly_no_tx", q.size(), 0);
    chk("hdronly_drop", DROP_CNT, 1);
    chk("hdronly_frame", FRAME_CNT, 1);
    // two-part payload: inner boundary must survive
    q.delete();
    send(HDRW, 7, 0, 1, 0, 0);
    send(64'h10, 7, 1, 1, 0, 1);
    send(64'h11, 7, 1, 1, 1, 0);
    send(64'h12, 7, 1, 1, 0, 1);
    send(64'h13, 4, 1, 0, 1, 0);
    idle(3);
    chk("parts_count", q.size(), 4);
    if (q.size() == 4) begin
      chk("parts_sop", {q[0].sop, q[1].sop, q[2].sop, q[3].sop}, 4'b0101);
      chk("parts_eop", {q[0].eop, q[1].eop, q[2].eop, q[3].eop}, 4'b1010);
      chk("parts_sof", {q[0].sof, q[1].sof, q[2].sof, q[3].sof}, 4'b0111);
      chk("parts_eof", {q[0].eof, q[1].eof, q[2].eof, q[3].eof}, 4'b1110);
    end
    chk("parts_frame", FRAME_CNT, 2);
    // random downstream backpressure
    q.delete();
    rand_rdy = 1;
    send(HDRW, 7, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) send(64'h100 + 64'(i), 7, 1, i == 7 ? 1'b0 : 1'b1, i == 0 ? 1'b0 : 1'b1, i == 7 ? 1'b0 : 1'b1);
    idle(20);
    rand_rdy = 0;
    TX_DST_RDY_N = 0;
    idle(3);
    chk("bp_count", q.size(), 8);
    foreach (q[i]) chk($sformatf("bp_data%0d", i), q[i].d, 64'h100 + 64'(i));
    chk("bp_frame", FRAME_CNT, 3);
    // 100 back-to-back frames
    q.delete();
    stalls = 0;
    for (int f = 0; f < 100; f++) begin
      send(HDRW, 7, 0, 1, 0, 1);
      send(HDRW, 7, 1, 1, 1, 0);
      for (int k = 0; k < 4; k++) send(64'h1000 + 64'(f * 4 + k), 7, 1, k == 3 ? 1'b0 : 1'b1, k == 0 ? 1'b0 : 1'b1, k == 3 ? 1'b0 : 1'b1);
    end
    idle(3);
    chk("b2b_stalls", stalls, 0);
    chk("b2b_count", q.size(), 400);
    foreach (q[i]) chk($sformatf("b2b_w%0d", i), {q[i].d, q[i].sof, q[i].eof}, {64'h1000 + 64'(i), i % 4 != 0, i % 4 != 3});
    chk("b2b_frame", FRAME_CNT, 103);
    // stray SOF inside payload restarts as a header
    q.delete();
    send(HDRW, 7, 0, 1, 0, 0);
    send(64'h51, 7, 1, 1, 0, 1);
    send(64'hEE, 7, 0, 1, 0, 0);
    send(64'h52, 3, 1, 0, 0, 0);
    idle(3);
    chk("perr_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("perr_w0", {q[0].d, q[0].sof, q[0].eof}, {64'h51, 2'b01});
      chk("perr_w1", {q[1].d, q[1].r, q[1].sof, q[1].sop, q[1].eof}, {64'h52, 3'd3, 3'b000});
    end
    chk("perr_drop", DROP_CNT, 2);
    chk("perr_frame", FRAME_CNT, 104);
    // reset in the middle of a payload
    send(HDRW, 7, 0, 1, 0, 0);
    send(64'h61, 7, 1, 1, 0, 1);
    send(64'h62, 7, 1, 1, 1, 1);
    RESET = 0;
    @(posedge CLK); #1;
    RESET = 1;
    chk("midrst_tx_src_rdy", TX_SRC_RDY_N, 1);
    chk("midrst_rx_dst_rdy", RX_DST_RDY_N, 1);
    chk("midrst_cnts", {FRAME_CNT, DROP_CNT}, 0);
    q.delete();
    send(HDRW, 7, 0, 1, 0, 0);
    send(64'h71, 7, 1, 1, 0, 1);
    send(64'h72, 6, 1, 0, 1, 0);
    idle(3);
    chk("midrst_count", q.size(), 2);
    if (q.size() == 2) begin
      chk("midrst_w0", {q[0].d, q[0].sof}, {64'h71, 1'b0});
      chk("midrst_w1", {q[1].d, q[1].r, q[1].eof}, {64'h72, 3'd6, 1'b0});
    end
    chk("midrst_frame", FRAME_CNT, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
